// File: rtl/addf_arb_if.sv
// rtl/addf_arb_if.sv - requester, response and shared-adder signals of addf_arb
// ADDF_ARB_OVF_EN adds the rsp_ovf signed-overflow flag.
interface addf_arb_if #(
    parameter int N = 4,
    parameter int W = 32
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [W-1:0]   rsp_data;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_sum;
    logic [IDW-1:0] grant_id;
    logic           busy;
`ifdef ADDF_ARB_OVF_EN
    logic           rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, rsp_ready, add_sum,
        input  req_ready, rsp_valid, rsp_data, add_a, add_b, grant_id, busy, rsp_ovf
    );
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, add_sum,
        output req_ready, rsp_valid, rsp_data, add_a, add_b, grant_id, busy, rsp_ovf
    );
`else
    modport master (
        output req_valid, req_a, req_b, rsp_ready, add_sum,
        input  req_ready, rsp_valid, rsp_data, add_a, add_b, grant_id, busy
    );
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, add_sum,
        output req_ready, rsp_valid, rsp_data, add_a, add_b, grant_id, busy
    );
`endif
endinterface

// File: rtl/addf_arb.sv
// rtl/addf_arb.sv - round-robin arbiter/sequencer sharing one external adder among N requesters
// ADDF_ARB_OVF_EN adds a registered signed-overflow flag (rsp_ovf) alongside rsp_data.
module addf_arb #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic       clk,
    input  logic       rst,
    addf_arb_if.slave  bus
);
    localparam int IDW = $clog2(N);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic [N-1:0]   rsp_valid_q, rsp_valid_d;
    logic           busy_q, busy_d;
    logic           ovf_q, ovf_d;
    logic [N-1:0]   req_ready_c;
    logic           win_found;
    logic [IDW-1:0] win_id;

    // First valid requester at or after ptr, wrapping modulo N.
    always_comb begin : pick
        logic [IDW:0] sum;
        sum       = '0;
        win_found = 1'b0;
        win_id    = ptr_q;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(N)) begin
                sum = sum - (IDW+1)'(N);
            end
            if (!win_found && bus.req_valid[sum[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = sum[IDW-1:0];
            end
        end
    end

    always_comb begin : next
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        ovf_d       = ovf_q;
        req_ready_c = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    req_ready_c[win_id] = 1'b1;
                    op_a_d     = bus.req_a[win_id*W +: W];
                    op_b_d     = bus.req_b[win_id*W +: W];
                    grant_id_d = win_id;
                    busy_d     = 1'b1;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d              = bus.add_sum;
                ovf_d                   = (op_a_q[W-1] == op_b_q[W-1]) &&
                                          (bus.add_sum[W-1] != op_a_q[W-1]);
                rsp_valid_d             = '0;
                rsp_valid_d[grant_id_q] = 1'b1;
                state_d                 = RESP;
            end
            RESP: begin
                // Only the owner's rsp_ready can complete the transfer.
                if (bus.rsp_ready[grant_id_q]) begin
                    rsp_valid_d = '0;
                    busy_d      = 1'b0;
                    ptr_d       = (grant_id_q == IDW'(N-1)) ? '0 : grant_id_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_id_q  <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.add_a     = op_a_q;
    assign bus.add_b     = op_b_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = busy_q;
`ifdef ADDF_ARB_OVF_EN
    assign bus.rsp_ovf   = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif
endmodule
